// File: rtl/bus_ctrl_pkg.sv
// Shared types and default constants for the bus controller and its wait generator.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        TO_NORMAL = 2'd1,
        NORMAL    = 2'd2,
        TO_BOOT   = 2'd3
    } reloc_state_t;

    localparam logic [15:0] DEF_RELOC_MASK  = 16'hC000;
    localparam logic [7:0]  DEF_RELOC_PORT  = 8'h1F;
    localparam int          DEF_NUM_IO      = 2;
    localparam logic [7:0]  DEF_IO_BASE     = 8'hFE;
    localparam int          DEF_WAIT_CYCLES = 2;
    localparam logic [3:0]  DEF_WAIT_PAGE   = 4'hC;

endpackage

// File: rtl/bus_wait_gen.sv
// Wait-state generator: stretches each qualifying memory/I-O access once by WAIT_CYCLES clocks.
module bus_wait_gen
    import bus_ctrl_pkg::*;
#(
    parameter int         WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [3:0] WAIT_PAGE   = DEF_WAIT_PAGE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] page,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    output logic       wait_n
);

    logic [3:0] count;
    logic [3:0] count_nxt;
    logic       done;
    logic       done_nxt;
    logic       qualify;
    logic       bus_idle;

    // Interrupt-acknowledge cycles (iorq_n=0 with m1_n=0) are not stretched.
    assign qualify  = ((!mreq_n && page == WAIT_PAGE) || (!iorq_n && m1_n)) && (!rd_n || !wr_n);
    assign bus_idle = mreq_n && iorq_n;

    always_comb begin
        count_nxt = count;
        done_nxt  = done;
        if (count != 4'd0) begin
            count_nxt = count - 4'd1;
            if (count == 4'd1) begin
                done_nxt = 1'b1;
            end
        end else if (!done && qualify) begin
            count_nxt = 4'(WAIT_CYCLES);
            done_nxt  = (WAIT_CYCLES == 0);
        end
        if (bus_idle) begin
            done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 4'd0;
            done   <= 1'b0;
            wait_n <= 1'b1;
        end else begin
            count  <= count_nxt;
            done   <= done_nxt;
            wait_n <= (count_nxt == 4'd0);
        end
    end

endmodule

// File: rtl/bus_ctrl.sv
// CPU bus controller: boot-time address relocation, strobe decode, I/O select and read mux.
// Optional wait-state generation is enabled by defining BUS_CTRL_WAIT_EN.
module bus_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter logic [15:0] RELOC_MASK  = DEF_RELOC_MASK,
    parameter logic [7:0]  RELOC_PORT  = DEF_RELOC_PORT,
    parameter int          NUM_IO      = DEF_NUM_IO,
    parameter logic [7:0]  IO_BASE     = DEF_IO_BASE,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [3:0]  WAIT_PAGE   = DEF_WAIT_PAGE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           a_raw,
    input  logic                  mreq_n,
    input  logic                  iorq_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic                  m1_n,
    input  logic [7:0]            cpu_dout,
    input  logic [7:0]            mem_dout,
    input  logic [NUM_IO*8-1:0]   io_dout,
    output logic [15:0]           addr,
    output logic [7:0]            cpu_din,
    output logic                  mem_en,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [NUM_IO-1:0]     io_sel,
    output logic                  wait_n,
    output logic                  reloc_active
);

    reloc_state_t state;
    reloc_state_t state_nxt;
    logic         ctrl_wr;
    logic [7:0]   io_byte;

    assign ctrl_wr      = !iorq_n && !wr_n && (a_raw[7:0] == RELOC_PORT);
    assign reloc_active = (state == BOOT) || (state == TO_NORMAL);
    assign addr         = reloc_active ? (a_raw | RELOC_MASK) : a_raw;

    assign mem_en = !mreq_n;
    assign mem_rd = !mreq_n && !rd_n;
    assign mem_wr = !mreq_n && !wr_n;

    // Ports are compared in 9 bits so a channel past 8'hFF can never alias onto a low port.
    always_comb begin
        io_sel = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (!iorq_n && m1_n && (({1'b0, IO_BASE} + 9'(i)) == {1'b0, a_raw[7:0]})) begin
                io_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        io_byte = 8'h00;
        for (int i = 0; i < NUM_IO; i++) begin
            if (io_sel[i]) begin
                io_byte = io_byte | io_dout[8*i +: 8];
            end
        end
        if (!mreq_n) begin
            cpu_din = mem_dout;
        end else if (io_sel != '0) begin
            cpu_din = io_byte;
        end else begin
            cpu_din = 8'hFF;
        end
    end

    // The TO_* states hold the old mapping until the OUT cycle finishes.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:      if (ctrl_wr && !cpu_dout[0]) state_nxt = TO_NORMAL;
            TO_NORMAL: if (iorq_n)                  state_nxt = NORMAL;
            NORMAL:    if (ctrl_wr && cpu_dout[0])  state_nxt = TO_BOOT;
            TO_BOOT:   if (iorq_n)                  state_nxt = BOOT;
            default:                                state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef BUS_CTRL_WAIT_EN
    bus_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .WAIT_PAGE   (WAIT_PAGE)
    ) u_wait_gen (
        .clk    (clk),
        .reset  (reset),
        .page   (a_raw[15:12]),
        .mreq_n (mreq_n),
        .iorq_n (iorq_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .m1_n   (m1_n),
        .wait_n (wait_n)
    );
`else
    assign wait_n = 1'b1;
`endif

endmodule
